// File: rtl/wbu_pkg.sv
// Shared types for the write-back unit.
// Load size encoding, default width and per-entry control bundle.
package wbu_pkg;

    localparam int XLEN_D = 32;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_e;

    // Width-independent control part of one buffered entry.
    typedef struct packed {
        logic [4:0] rd;
        logic [3:0] csr_wen;
        logic       r_wen;
        logic       mem_ren;
        logic       jump;
        logic       ld_unsigned;
        ld_size_e   ld_size;
        logic [1:0] ld_off;
    } wb_entry_t;

endpackage

// File: rtl/wbu_fifo.sv
// Small synchronous FIFO holding write-back entries.
// Power-of-two depth; head word is visible whenever not empty.
module wbu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
            if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wbu_pipe.sv
// Write-back stage: buffers retiring entries and forms regfile/CSR strobes.
// Result select and sub-word load extraction act on the head entry.
module wbu_pipe
    import wbu_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 32,
    parameter int LOAD_EXT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready,
    input  logic [XLEN-1:0]  mem_rdata_in,
    input  logic [XLEN-1:0]  ex_result_in,
    input  logic [XLEN-1:0]  rd_value_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [4:0]       rd_in,
    input  logic [3:0]       csr_wen_in,
    input  logic             r_wen_in,
    input  logic             mem_ren_in,
    input  logic             jump_flag_in,
    input  logic             ld_unsigned_in,
    input  logic [1:0]       ld_size_in,
    input  logic [1:0]       ld_off_in,
    input  logic             commit_ready,
    output logic             valid_next,
    output logic             r_wen_next,
    output logic [3:0]       csr_wen_next,
    output logic [4:0]       rd_next,
    output logic [XLEN-1:0]  rd_value_next,
    output logic [XLEN-1:0]  csrd,
    output logic [XLEN-1:0]  pc_out,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int W = $bits(wb_entry_t) + 4 * XLEN;

    wb_entry_t        in_c, hd_c;
    logic [XLEN-1:0]  hd_mem, hd_ex, hd_rdv, hd_pc;
    logic [W-1:0]     wdata, rdata;
    logic             full, empty, push, pop;
    logic [XLEN-1:0]  shifted, ld_val;
    logic [CNT_W-1:0] ret_q, ret_d;

    always_comb begin
        in_c.rd          = rd_in;
        in_c.csr_wen     = csr_wen_in;
        in_c.r_wen       = r_wen_in;
        in_c.mem_ren     = mem_ren_in;
        in_c.jump        = jump_flag_in;
        in_c.ld_unsigned = ld_unsigned_in;
        in_c.ld_size     = ld_size_e'(ld_size_in);
        in_c.ld_off      = ld_off_in;
    end

    assign wdata = {in_c, mem_rdata_in, ex_result_in, rd_value_in, pc_in};
    assign {hd_c, hd_mem, hd_ex, hd_rdv, hd_pc} = rdata;

    assign ready      = !full;
    assign valid_next = !empty;
    assign push       = valid_in && ready && !flush;
    assign pop        = valid_next && commit_ready && !flush;

    wbu_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    assign shifted = hd_mem >> {hd_c.ld_off, 3'b000};

    // Size code 3 falls through to the word case.
    always_comb begin
        ld_val = hd_mem;
        if (LOAD_EXT != 0) begin
            unique case (1'b1)
                (hd_c.ld_size == LD_B):
                    ld_val = {{(XLEN-8){shifted[7] & ~hd_c.ld_unsigned}},
                              shifted[7:0]};
                (hd_c.ld_size == LD_H):
                    ld_val = {{(XLEN-16){shifted[15] & ~hd_c.ld_unsigned}},
                              shifted[15:0]};
                default:
                    ld_val = shifted;
            endcase
        end
    end

    always_comb begin
        rd_value_next = hd_ex;
        if (hd_c.jump || (|hd_c.csr_wen)) rd_value_next = hd_rdv;
        else if (hd_c.mem_ren)            rd_value_next = ld_val;
    end

    assign r_wen_next   = hd_c.r_wen && valid_next && (hd_c.rd != 5'd0);
    assign csr_wen_next = hd_c.csr_wen & {4{valid_next}};
    assign rd_next      = hd_c.rd;
    assign csrd         = hd_ex;
    assign pc_out       = hd_pc;

    assign ret_d = pop ? ret_q + 1'b1 : ret_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ret_q <= '0;
        else        ret_q <= ret_d;
    end

    assign retire_cnt = ret_q;

endmodule

// File: tb/tb_wbu_pipe.sv
// Directed bench for wbu_pipe with hand-computed expectations.
// Default parameters: XLEN 32, DEPTH 2.
module tb_wbu_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready;
    logic [31:0] mem_rdata_in = '0, ex_result_in = '0;
    logic [31:0] rd_value_in = '0, pc_in = '0;
    logic [4:0]  rd_in = '0;
    logic [3:0]  csr_wen_in = '0;
    logic        r_wen_in = 1'b0, mem_ren_in = 1'b0;
    logic        jump_flag_in = 1'b0, ld_unsigned_in = 1'b0;
    logic [1:0]  ld_size_in = '0, ld_off_in = '0;
    logic        commit_ready = 1'b0;
    logic        valid_next, r_wen_next;
    logic [3:0]  csr_wen_next;
    logic [4:0]  rd_next;
    logic [31:0] rd_value_next, csrd, pc_out, retire_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clock = ~clock;

    wbu_pipe dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .valid_in       (valid_in),
        .ready          (ready),
        .mem_rdata_in   (mem_rdata_in),
        .ex_result_in   (ex_result_in),
        .rd_value_in    (rd_value_in),
        .pc_in          (pc_in),
        .rd_in          (rd_in),
        .csr_wen_in     (csr_wen_in),
        .r_wen_in       (r_wen_in),
        .mem_ren_in     (mem_ren_in),
        .jump_flag_in   (jump_flag_in),
        .ld_unsigned_in (ld_unsigned_in),
        .ld_size_in     (ld_size_in),
        .ld_off_in      (ld_off_in),
        .commit_ready   (commit_ready),
        .valid_next     (valid_next),
        .r_wen_next     (r_wen_next),
        .csr_wen_next   (csr_wen_next),
        .rd_next        (rd_next),
        .rd_value_next  (rd_value_next),
        .csrd           (csrd),
        .pc_out         (pc_out),
        .retire_cnt     (retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] ex, rdv, mem, pc,
                         input logic [4:0] rd, input logic [3:0] csr,
                         input logic rw, mr, jf, uns,
                         input logic [1:0] sz, off);
        valid_in       = 1'b1;
        ex_result_in   = ex;
        rd_value_in    = rdv;
        mem_rdata_in   = mem;
        pc_in          = pc;
        rd_in          = rd;
        csr_wen_in     = csr;
        r_wen_in       = rw;
        mem_ren_in     = mr;
        jump_flag_in   = jf;
        ld_unsigned_in = uns;
        ld_size_in     = sz;
        ld_off_in      = off;
    endtask

    task automatic pop_one(input string tag);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        exp_ret++;
        chk({tag, "_ret"}, retire_cnt, exp_ret);
        chk({tag, "_empty"}, valid_next, 1'b0);
    endtask

    task automatic load_case(input string tag, input logic uns,
                             input logic [1:0] sz, off,
                             input logic [31:0] exp);
        commit_ready = 1'b0;
        drive(32'hDEAD, 32'hBEEF, 32'h80FF7F01, 32'h40, 5'd7, 4'h0,
              1'b1, 1'b1, 1'b0, uns, sz, off);
        tick();
        valid_in = 1'b0;
        chk(tag, rd_value_next, exp);
        pop_one(tag);
    endtask

    initial begin
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", valid_next, 1'b0);
        chk("rst_rwen", r_wen_next, 1'b0);
        chk("rst_csr", csr_wen_next, 4'h0);
        chk("rst_ret", retire_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        commit_ready = 1'b1;
        drive(32'h1234, 32'h0, 32'h0, 32'h100, 5'd5, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
        tick();
        valid_in = 1'b0;
        chk("alu_valid", valid_next, 1'b1);
        chk("alu_val", rd_value_next, 32'h1234);
        chk("alu_rwen", r_wen_next, 1'b1);
        chk("alu_rd", rd_next, 5'd5);
        chk("alu_pc", pc_out, 32'h100);
        tick();
        exp_ret++;
        chk("alu_ret", retire_cnt, exp_ret);
        chk("alu_empty", valid_next, 1'b0);
        commit_ready = 1'b0;

        load_case("lb_off2",  1'b0, 2'd0, 2'd2, 32'hFFFFFFFF);
        load_case("lbu_off2", 1'b1, 2'd0, 2'd2, 32'h000000FF);
        load_case("lh_off2",  1'b0, 2'd1, 2'd2, 32'hFFFF80FF);
        load_case("lhu_off2", 1'b1, 2'd1, 2'd2, 32'h000080FF);
        load_case("lb_off1",  1'b0, 2'd0, 2'd1, 32'h0000007F);
        load_case("lh_off0",  1'b0, 2'd1, 2'd0, 32'h00007F01);
        load_case("lw",       1'b0, 2'd2, 2'd0, 32'h80FF7F01);
        load_case("lsz3",     1'b1, 2'd3, 2'd0, 32'h80FF7F01);

        commit_ready = 1'b0;
        drive(32'h11, 0, 0, 32'h200, 5'd1, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        chk("bp_ready1", ready, 1'b1);
        drive(32'h22, 0, 0, 32'h204, 5'd2, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        chk("bp_ready2", ready, 1'b0);
        drive(32'h33, 0, 0, 32'h208, 5'd3, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        chk("bp_hold_ready", ready, 1'b0);
        chk("bp_hold_head", rd_value_next, 32'h11);
        commit_ready = 1'b1;
        tick();
        chk("bp_head_b", rd_value_next, 32'h22);
        chk("bp_rd_b", rd_next, 5'd2);
        chk("bp_ready3", ready, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("bp_head_c", rd_value_next, 32'h33);
        chk("bp_pc_c", pc_out, 32'h208);
        tick();
        commit_ready = 1'b0;
        exp_ret += 3;
        chk("bp_ret", retire_cnt, exp_ret);
        chk("bp_empty", valid_next, 1'b0);

        drive(32'h77, 0, 0, 0, 5'd0, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        valid_in = 1'b0;
        chk("x0_valid", valid_next, 1'b1);
        chk("x0_rwen", r_wen_next, 1'b0);
        pop_one("x0");

        drive(32'h200, 32'h104, 0, 32'h100, 5'd1, 4'h0, 1'b1, 1'b0,
              1'b1, 1'b0, 2'd2, 2'd0);
        tick();
        valid_in = 1'b0;
        chk("jal_val", rd_value_next, 32'h104);
        chk("jal_rwen", r_wen_next, 1'b1);
        pop_one("jal");

        drive(32'hABCD, 32'h55, 0, 32'h300, 5'd3, 4'h1, 1'b1, 1'b0,
              1'b0, 1'b0, 2'd2, 2'd0);
        tick();
        valid_in = 1'b0;
        chk("csr_wen", csr_wen_next, 4'h1);
        chk("csr_d", csrd, 32'hABCD);
        chk("csr_val", rd_value_next, 32'h55);
        pop_one("csr");

        drive(32'h1, 0, 0, 0, 5'd4, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        drive(32'h2, 0, 0, 0, 5'd4, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        chk("fl_full", ready, 1'b0);
        flush = 1'b1;
        commit_ready = 1'b1;
        drive(32'h3, 0, 0, 0, 5'd4, 4'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        flush = 1'b0;
        valid_in = 1'b0;
        commit_ready = 1'b0;
        chk("fl_valid", valid_next, 1'b0);
        chk("fl_ready", ready, 1'b1);
        chk("fl_ret", retire_cnt, exp_ret);
        tick();
        chk("fl_nopush", valid_next, 1'b0);

        drive(32'h9, 32'h9, 0, 0, 5'd6, 4'h3, 1'b1, 1'b0, 1'b0,
              1'b0, 2'd2, 2'd0);
        tick();
        valid_in = 1'b0;
        chk("mr_valid", valid_next, 1'b1);
        chk("mr_csr", csr_wen_next, 4'h3);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_valid0", valid_next, 1'b0);
        chk("mr_rwen0", r_wen_next, 1'b0);
        chk("mr_csr0", csr_wen_next, 4'h0);
        chk("mr_ready", ready, 1'b1);
        chk("mr_ret0", retire_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("mr_discard", valid_next, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
